target_hit_judge: RTL and testbench

// - Consumer of the ball target position: latches ball_x/ball_y, judges player clicks against the 40x40 target box, and measures reaction time in ms.
// - Issues the new_ball request back to the ball generator after each hit or timeout, closing the target loop.
// - Sits between the ball generator and the score/time display logic.

---
 rtl/reflex_pkg.sv | 30 +++
 rtl/ms_tick_gen.sv | 29 ++
 rtl/target_hit_judge.sv | 154 +++++++++++++++
 tb/tb_target_hit_judge.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reflex_pkg.sv
// Shared types and screen geometry for the reflex-trainer datapath.
// Used by the target generator, hit judge and display logic.
package reflex_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ACTIVE,
        RESULT
    } state_t;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int BALL_SIZE = 40;
    localparam int HUD_H     = 40;

    // Inclusive span test done one bit wider so origin+size never wraps.
    function automatic logic in_span(input logic [9:0] pos,
                                     input logic [9:0] origin,
                                     input int         size);
        logic [10:0] p;
        logic [10:0] lo;
        logic [10:0] hi;
        p  = {1'b0, pos};
        lo = {1'b0, origin};
        hi = lo + 11'(size) - 11'd1;
        return (p >= lo) && (p <= hi);
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running prescaler that emits a one-cycle tick every DIV clocks.
// clr restarts the period so the first tick lands exactly DIV cycles later.
module ms_tick_gen #(
    parameter int DIV = 25_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/target_hit_judge.sv
// Latches the target position, judges clicks against the target box and
// times the player's reaction in ms; requests a new target after each trial.
module target_hit_judge
    import reflex_pkg::*;
#(
    parameter int CLK_HZ     = 25_000_000,
    parameter int BALL_SIZE  = reflex_pkg::BALL_SIZE,
    parameter int TIMEOUT_MS = 2000,
    parameter int LOAD_CYC   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_en,
    input  logic        start,
    input  logic        click,
    input  logic [9:0]  cur_x,
    input  logic [9:0]  cur_y,
    input  logic [9:0]  ball_x,
    input  logic [9:0]  ball_y,
    output logic        new_ball,
    output logic        hit_pulse,
    output logic        miss_pulse,
    output logic [7:0]  hit_cnt,
    output logic [7:0]  miss_cnt,
    output logic [15:0] react_ms,
    output logic        active
);

    localparam int MS_DIV = CLK_HZ / 1000;
    localparam int LCW    = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;
    localparam logic [LCW-1:0] LOAD_LAST = LCW'(LOAD_CYC - 1);
    localparam logic [15:0]    MS_LAST   = 16'(TIMEOUT_MS - 1);

    state_t         state, state_nxt;
    logic [LCW-1:0] load_cnt, load_nxt;
    logic [9:0]     bx, bx_nxt;
    logic [9:0]     by, by_nxt;
    logic [15:0]    ms_cnt, ms_nxt;
    logic [7:0]     hit_nxt, miss_nxt;
    logic [15:0]    react_nxt;
    logic           hit_p_nxt, miss_p_nxt;
    logic           tick_clr;
    logic           ms_tick;
    logic           box_hit;

    ms_tick_gen #(
        .DIV (MS_DIV)
    ) u_ms_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .tick (ms_tick)
    );

    assign box_hit = click && in_span(cur_x, bx, BALL_SIZE)
                           && in_span(cur_y, by, BALL_SIZE);

    // A hit is checked before the timeout so a click on the final tick still wins.
    always_comb begin
        state_nxt  = state;
        load_nxt   = load_cnt;
        bx_nxt     = bx;
        by_nxt     = by;
        ms_nxt     = ms_cnt;
        hit_nxt    = hit_cnt;
        miss_nxt   = miss_cnt;
        react_nxt  = react_ms;
        hit_p_nxt  = 1'b0;
        miss_p_nxt = 1'b0;
        tick_clr   = 1'b0;

        if (!game_en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        hit_nxt   = '0;
                        miss_nxt  = '0;
                        react_nxt = '0;
                        load_nxt  = '0;
                        state_nxt = LOAD;
                    end
                end
                LOAD: begin
                    if (load_cnt == LOAD_LAST) begin
                        bx_nxt    = ball_x;
                        by_nxt    = ball_y;
                        ms_nxt    = '0;
                        tick_clr  = 1'b1;
                        state_nxt = ACTIVE;
                    end else begin
                        load_nxt = load_cnt + LCW'(1);
                    end
                end
                ACTIVE: begin
                    if (box_hit) begin
                        react_nxt = ms_cnt;
                        hit_nxt   = (hit_cnt == 8'hFF) ? hit_cnt : hit_cnt + 8'd1;
                        hit_p_nxt = 1'b1;
                        state_nxt = RESULT;
                    end else if (ms_tick) begin
                        if (ms_cnt == MS_LAST) begin
                            miss_nxt   = (miss_cnt == 8'hFF) ? miss_cnt : miss_cnt + 8'd1;
                            miss_p_nxt = 1'b1;
                            state_nxt  = RESULT;
                        end else if (ms_cnt != 16'hFFFF) begin
                            ms_nxt = ms_cnt + 16'd1;
                        end
                    end
                end
                RESULT: begin
                    load_nxt  = '0;
                    state_nxt = LOAD;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Pulses and active are registered off the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            load_cnt   <= '0;
            bx         <= '0;
            by         <= '0;
            ms_cnt     <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            react_ms   <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            new_ball   <= 1'b0;
            active     <= 1'b0;
        end else begin
            state      <= state_nxt;
            load_cnt   <= load_nxt;
            bx         <= bx_nxt;
            by         <= by_nxt;
            ms_cnt     <= ms_nxt;
            hit_cnt    <= hit_nxt;
            miss_cnt   <= miss_nxt;
            react_ms   <= react_nxt;
            hit_pulse  <= hit_p_nxt;
            miss_pulse <= miss_p_nxt;
            new_ball   <= (state_nxt == RESULT);
            active     <= (state_nxt == ACTIVE);
        end
    end

endmodule

// File: tb/tb_target_hit_judge.sv
// Self-checking bench for target_hit_judge: a table of trials feeds a pulse
// scoreboard, followed by hand-written enable, saturation and reset sequences.
module tb_target_hit_judge;

    localparam int CLK_HZ      = 10_000;
    localparam int TIMEOUT_MS  = 5;
    localparam int LOAD_CYC    = 2;
    localparam int CYC_PER_MS  = CLK_HZ / 1000;
    localparam int TIMEOUT_CYC = TIMEOUT_MS * CYC_PER_MS;
    localparam int NVEC        = 12;

    typedef struct {
        logic [9:0]  bx;
        logic [9:0]  by;
        logic [9:0]  cx;
        logic [9:0]  cy;
        int          click_k;
        bit          exp_hit;
        logic [15:0] exp_react;
    } vec_t;

    typedef struct {
        int          cyc;
        bit          nb;
        bit          hit;
        bit          miss;
        logic [7:0]  hc;
        logic [7:0]  mc;
        logic [15:0] react;
    } evt_t;

    logic        clk;
    logic        rst;
    logic        game_en;
    logic        start;
    logic        click;
    logic [9:0]  cur_x;
    logic [9:0]  cur_y;
    logic [9:0]  ball_x;
    logic [9:0]  ball_y;
    logic        new_ball;
    logic        hit_pulse;
    logic        miss_pulse;
    logic [7:0]  hit_cnt;
    logic [7:0]  miss_cnt;
    logic [15:0] react_ms;
    logic        active;

    int          checks;
    int          errors;
    int          cyc;
    int          last_pulse_cyc;
    logic [7:0]  exp_hc;
    logic [7:0]  exp_mc;
    logic [15:0] exp_react;
    evt_t        exp_q[$];
    evt_t        obs_q[$];
    vec_t        vecs[NVEC];

    target_hit_judge #(
        .CLK_HZ     (CLK_HZ),
        .BALL_SIZE  (40),
        .TIMEOUT_MS (TIMEOUT_MS),
        .LOAD_CYC   (LOAD_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .game_en    (game_en),
        .start      (start),
        .click      (click),
        .cur_x      (cur_x),
        .cur_y      (cur_y),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .new_ball   (new_ball),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt),
        .react_ms   (react_ms),
        .active     (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every observed pulse cycle is captured with the counters it carries.
    always @(negedge clk) begin
        if (new_ball || hit_pulse || miss_pulse)
            obs_q.push_back('{cyc, new_ball, hit_pulse, miss_pulse, hit_cnt, miss_cnt, react_ms});
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic pushExpect(input int at, input bit h, input logic [15:0] r);
        if (h) begin
            exp_hc    = (exp_hc == 8'd255) ? 8'd255 : exp_hc + 8'd1;
            exp_react = r;
        end else begin
            exp_mc = (exp_mc == 8'd255) ? 8'd255 : exp_mc + 8'd1;
        end
        exp_q.push_back('{at, 1'b1, h, !h, exp_hc, exp_mc, exp_react});
    endtask

    task automatic drainScoreboard();
        evt_t o;
        evt_t e;
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pulse: got pulse at cycle %0d expected none", o.cyc);
            end else begin
                e = exp_q.pop_front();
                checkOutput("evt_cycle", o.cyc, e.cyc);
                checkOutput("evt_new_ball", 32'(o.nb), 32'(e.nb));
                checkOutput("evt_hit_pulse", 32'(o.hit), 32'(e.hit));
                checkOutput("evt_miss_pulse", 32'(o.miss), 32'(e.miss));
                checkOutput("evt_hit_cnt", 32'(o.hc), 32'(e.hc));
                checkOutput("evt_miss_cnt", 32'(o.mc), 32'(e.mc));
                checkOutput("evt_react_ms", 32'(o.react), 32'(e.react));
            end
        end
    endtask

    task automatic waitActive(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (active) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL active_timeout: got active=0 expected active=1 within 40 cycles");
        end else if (last_pulse_cyc >= 0) begin
            checkOutput("active_latency", cyc, last_pulse_cyc + 1 + LOAD_CYC);
        end
    endtask

    task automatic waitResult();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (new_ball) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!found) begin
            checks++;
            errors++;
            $display("[TB] FAIL result_timeout: got new_ball=0 expected new_ball=1 within 80 cycles");
        end else begin
            last_pulse_cyc = cyc;
        end
        #1;
        drainScoreboard();
    endtask

    task automatic startRound();
        @(negedge clk);
        start = 1'b1;
        last_pulse_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One trial: wait for the target, present the next ball early, click or not.
    task automatic applyStimulus(input vec_t v, input logic [9:0] nbx, input logic [9:0] nby);
        int a;
        bit ok;
        waitActive(ok);
        if (!ok) return;
        a = cyc;
        ball_x = nbx;
        ball_y = nby;
        if (v.click_k >= 0) begin
            repeat (v.click_k) @(negedge clk);
            cur_x = v.cx;
            cur_y = v.cy;
            click = 1'b1;
            if (v.exp_hit) pushExpect(cyc + 1, 1'b1, v.exp_react);
            @(negedge clk);
            click = 1'b0;
        end
        if (!v.exp_hit) pushExpect(a + TIMEOUT_CYC, 1'b0, 16'd0);
        waitResult();
    endtask

    initial begin
        vec_t sv;
        bit   ok;

        checks = 0;
        errors = 0;
        cyc = 0;
        last_pulse_cyc = -1;
        exp_hc = '0;
        exp_mc = '0;
        exp_react = '0;
        rst = 1'b1;
        game_en = 1'b1;
        start = 1'b0;
        click = 1'b0;
        cur_x = '0;
        cur_y = '0;
        ball_x = 10'd100;
        ball_y = 10'd200;

        vecs[0]  = '{10'd100,  10'd200, 10'd120,  10'd220, 30, 1'b1, 16'd3};
        vecs[1]  = '{10'd100,  10'd200, 10'd139,  10'd239,  5, 1'b1, 16'd0};
        vecs[2]  = '{10'd100,  10'd200, 10'd140,  10'd200, 12, 1'b0, 16'd0};
        vecs[3]  = '{10'd100,  10'd200, 10'd99,   10'd200, 20, 1'b0, 16'd0};
        vecs[4]  = '{10'd100,  10'd200, 10'd100,  10'd239, 21, 1'b1, 16'd2};
        vecs[5]  = '{10'd100,  10'd200, 10'd100,  10'd240, 15, 1'b0, 16'd0};
        vecs[6]  = '{10'd100,  10'd200, 10'd0,    10'd0,   -1, 1'b0, 16'd0};
        vecs[7]  = '{10'd100,  10'd200, 10'd110,  10'd210, 49, 1'b1, 16'd4};
        vecs[8]  = '{10'd100,  10'd200, 10'd120,  10'd220,  8, 1'b1, 16'd0};
        vecs[9]  = '{10'd300,  10'd200, 10'd310,  10'd210, 40, 1'b1, 16'd4};
        vecs[10] = '{10'd600,  10'd440, 10'd639,  10'd479, 10, 1'b1, 16'd1};
        vecs[11] = '{10'd1000, 10'd200, 10'd1023, 10'd239,  0, 1'b1, 16'd0};

        repeat (3) @(negedge clk);
        checkOutput("reset_new_ball", 32'(new_ball), 0);
        checkOutput("reset_hit_pulse", 32'(hit_pulse), 0);
        checkOutput("reset_miss_pulse", 32'(miss_pulse), 0);
        checkOutput("reset_hit_cnt", 32'(hit_cnt), 0);
        checkOutput("reset_miss_cnt", 32'(miss_cnt), 0);
        checkOutput("reset_react_ms", 32'(react_ms), 0);
        checkOutput("reset_active", 32'(active), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("idle_before_start", 32'(active), 0);

        ball_x = vecs[0].bx;
        ball_y = vecs[0].by;
        startRound();
        checkOutput("start_clears_hits", 32'(hit_cnt), 0);
        for (int i = 0; i < NVEC; i++)
            applyStimulus(vecs[i], vecs[(i + 1) % NVEC].bx, vecs[(i + 1) % NVEC].by);

        // Start mid-trial must be ignored, then dropping game_en parks in IDLE.
        waitActive(ok);
        if (ok) begin
            repeat (2) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (2) @(negedge clk);
            game_en = 1'b0;
            @(negedge clk);
            checkOutput("disable_active", 32'(active), 0);
            checkOutput("disable_hit_cnt", 32'(hit_cnt), 32'(exp_hc));
            checkOutput("disable_miss_cnt", 32'(miss_cnt), 32'(exp_mc));
            checkOutput("disable_react_ms", 32'(react_ms), 32'(exp_react));
            for (int i = 0; i < 6; i++) begin
                cur_x = 10'd110;
                cur_y = 10'd210;
                click = 1'b1;
                @(negedge clk);
                click = 1'b0;
                repeat (8) @(negedge clk);
            end
            game_en = 1'b1;
            repeat (20) @(negedge clk);
            checkOutput("idle_without_start", 32'(active), 0);
            checkOutput("idle_hit_cnt_held", 32'(hit_cnt), 32'(exp_hc));
            #1;
            drainScoreboard();
        end

        // Saturation run: 256 immediate hits on a fresh round.
        ball_x = 10'd100;
        ball_y = 10'd200;
        startRound();
        checkOutput("restart_hit_cnt", 32'(hit_cnt), 0);
        checkOutput("restart_miss_cnt", 32'(miss_cnt), 0);
        checkOutput("restart_react_ms", 32'(react_ms), 0);
        exp_hc = '0;
        exp_mc = '0;
        exp_react = '0;
        sv = '{10'd100, 10'd200, 10'd100, 10'd200, 0, 1'b1, 16'd0};
        for (int n = 0; n < 256; n++)
            applyStimulus(sv, 10'd100, 10'd200);
        checkOutput("hit_cnt_saturated", 32'(hit_cnt), 255);

        // Reset in the middle of a live target.
        waitActive(ok);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_new_ball", 32'(new_ball), 0);
        checkOutput("midrst_hit_pulse", 32'(hit_pulse), 0);
        checkOutput("midrst_miss_pulse", 32'(miss_pulse), 0);
        checkOutput("midrst_hit_cnt", 32'(hit_cnt), 0);
        checkOutput("midrst_miss_cnt", 32'(miss_cnt), 0);
        checkOutput("midrst_react_ms", 32'(react_ms), 0);
        checkOutput("midrst_active", 32'(active), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("post_reset_idle", 32'(active), 0);
        #1;
        drainScoreboard();
        checkOutput("pending_expected_events", exp_q.size(), 0);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
